noc_output_arbiter: RTL and testbench
=====================================

Name: noc_output_arbiter

Overview:
- Per-output-port switch allocator for the NoC router.
- Arbitrates wormhole packets from N input ports onto one output link using round-robin priority. Holds the grant from head flit to tail flit.
- Drives a one-hot grant vector that steers the one-hot output multiplexer, and registers the selected flit into a single output stage with a valid/ready handshake.

Parameters:
- N, 5, number of requesting input ports; legal range 1..16.
- DataWidth, 32, flit payload width in bits.
- CntWidth, 16, width of the forwarded-packet counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  N  per-input flit valid.
- req_head  input  N  per-input flag: the presented flit is a head flit.
- req_tail  input  N  per-input flag: the presented flit is a tail flit. Head and tail both set means a single-flit packet.
- req_data  input  N x DataWidth  per-input flit payload, packed [N-1:0][DataWidth-1:0].
- req_ready  output  N  per-input flit accept.
- grant  output  N  one-hot grant to the datapath mux; all zero when idle.
- out_valid  output  1  output flit valid.
- out_data  output  DataWidth  output flit payload.
- out_ready  input  1  downstream accept.
- locked  output  1  high while a packet owns the output.
- pkt_count  output  CntWidth  count of tail flits forwarded; wraps modulo 2^CntWidth.

Behaviour:
- Reset (async assert, sync release) clears:
  - grant=0, locked=0, out_valid=0, out_data=0, pkt_count=0.
  - Priority pointer ptr=0, FSM state=IDLE.
- Reset asserted mid-packet discards the packet state and the output register contents with no completion.
- Transfer definitions:
  - Input transfer on input i: req_valid[i] && req_ready[i].
  - Output transfer: out_valid && out_ready.
- req_ready[i] = grant[i] && (!out_valid || out_ready). This is combinational and is zero for non-granted inputs.
- FSM IDLE:
  - Candidates are inputs with req_valid && req_head.
  - The winner is the first candidate found scanning i = ptr, ptr+1, ..., wrapping modulo N.
  - If any candidate exists: at the next edge grant <= onehot(winner), locked <= 1, state <= LOCKED.
  - If no candidate exists: stay in IDLE.
  - Valid non-head flits are ignored in IDLE and are never granted.
- FSM LOCKED:
  - On an input transfer from the granted input, out_data <= req_data[granted] and out_valid <= 1.
  - If the transferred flit has req_tail=1:
    - grant <= 0, locked <= 0, state <= IDLE.
    - ptr <= (granted+1) mod N.
    - pkt_count <= pkt_count+1.
  - Requests from other inputs are ignored while LOCKED. The granted input may stall (req_valid=0) for any number of cycles without losing the lock.
- Output register:
  - Output transfer with no new input transfer: out_valid <= 0.
  - out_ready=0 while out_valid=1: out_data and out_valid hold stable.
  - Simultaneous output transfer and input transfer in the same cycle: new flit loaded, full throughput, one flit per cycle.
- Latency:
  - Head request at cycle t: grant at t+1, head accepted at t+1, out_valid at t+2.
  - Back-to-back packets incur one idle arbitration cycle between tail and next head.
- grant is always one-hot or zero. It never changes while locked=1.
- N=1: the pointer is a constant 0 and the behaviour is otherwise identical.

Test Plan:
1. Reset then single flit: N=5, in2 presents head+tail, data=0xA5A5_0002, out_ready=1.
   - Required: grant=5'b00100 at t+1, out_valid=1 with out_data=0xA5A5_0002 at t+2.
   - Required: grant=0 and locked=0 at t+2, pkt_count=1.
2. Round-robin fairness: all 5 inputs continuously offer single-flit packets, out_ready=1.
   - Required grant order from ptr=0: 0,1,2,3,4,0.
   - Required: each winner's data appears in that order, one packet per 2 cycles.
3. Wormhole lock: in1 sends a 4-flit packet (head, 2 body, tail) while in3 requests a head at the same time.
   - Required: in3 req_ready stays 0 until in1's tail transfers.
   - Required: in1's 4 flits appear contiguous on out_data, then grant=5'b01000.
4. Backpressure: out_ready=0 for 3 cycles mid-packet.
   - Required: out_data/out_valid held stable, granted req_ready=0, no flit lost or duplicated.
   - Required: sequence resumes exactly when out_ready=1.
5. Reset mid-packet: assert rst_n=0 after the body flit of a 3-flit packet.
   - Required: all outputs at reset values immediately, ptr=0.
   - Required: a following in4 head is granted normally.
6. Stray body flit: in0 asserts req_valid with head=0 in IDLE.
   - Required: no grant, req_ready[0]=0, pkt_count unchanged.

Source files
------------

// File: rtl/noc_output_arbiter.sv
// Per-output-port wormhole switch allocator: round-robin head arbitration, grant held
// from head to tail, and a single registered output stage with valid/ready handshake.
module noc_output_arbiter #(
   parameter int N         = 5,
   parameter int DataWidth = 32,
   parameter int CntWidth  = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N-1:0]                  req_valid,
   input  logic [N-1:0]                  req_head,
   input  logic [N-1:0]                  req_tail,
   input  logic [N-1:0][DataWidth-1:0]   req_data,
   output logic [N-1:0]                  req_ready,
   output logic [N-1:0]                  grant,
   output logic                          out_valid,
   output logic [DataWidth-1:0]          out_data,
   input  logic                          out_ready,
   output logic                          locked,
   output logic [CntWidth-1:0]           pkt_count
);

   localparam int PtrW = (N > 1) ? $clog2(N) : 1;
   localparam logic [PtrW-1:0] LAST_IDX = PtrW'(N - 1);
   localparam logic [0:0] STATE_IDLE   = 1'b0;
   localparam logic [0:0] STATE_LOCKED = 1'b1;

   // Handshake: a flit moves on a side when its valid and ready are both high in
   // the same cycle; valid never depends on ready.
   logic [0:0]            state_q, state_d;
   logic [N-1:0]          grant_q, grant_d;
   logic [PtrW-1:0]       ptr_q, ptr_d;
   logic                  out_valid_q, out_valid_d;
   logic [DataWidth-1:0]  out_data_q, out_data_d;
   logic [CntWidth-1:0]   pkt_count_q, pkt_count_d;

   logic [N-1:0]          cand;
   logic [N-1:0]          win_oh;
   logic                  win_found;
   logic [PtrW-1:0]       gidx;
   logic                  stage_free;
   logic                  in_xfer;
   int                    idx;

   assign cand = req_valid & req_head;

   // First head candidate scanning upward from the priority pointer, wrapping at N.
   always_comb begin
      win_found = 1'b0;
      win_oh    = '0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= N) idx = idx - N;
         if (!win_found && cand[idx]) begin
            win_found   = 1'b1;
            win_oh[idx] = 1'b1;
         end
      end
   end

   always_comb begin
      gidx = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_q[i]) gidx = PtrW'(i);
      end
   end

   assign stage_free = !out_valid_q || out_ready;
   assign req_ready  = grant_q & {N{stage_free}};
   assign in_xfer    = |(req_valid & req_ready);

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      pkt_count_d = pkt_count_q;

      if (in_xfer) begin
         out_data_d  = req_data[gidx];
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         STATE_IDLE: begin
            if (win_found) begin
               grant_d = win_oh;
               state_d = STATE_LOCKED;
            end
         end
         default: begin
            if (in_xfer && req_tail[gidx]) begin
               grant_d     = '0;
               state_d     = STATE_IDLE;
               ptr_d       = (gidx == LAST_IDX) ? '0 : gidx + PtrW'(1);
               pkt_count_d = pkt_count_q + CntWidth'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= STATE_IDLE;
         grant_q     <= '0;
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         pkt_count_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         pkt_count_q <= pkt_count_d;
      end
   end

   assign grant     = grant_q;
   assign locked    = (state_q == STATE_LOCKED);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed bench for noc_output_arbiter (N=5): arbitration order, wormhole lock,
// backpressure, mid-packet reset and stray body flits, against hand-computed values.
module tb_noc_output_arbiter;

   localparam int N  = 5;
   localparam int DW = 32;
   localparam int CW = 16;

   logic                 clk;
   logic                 rst_n;
   logic [N-1:0]         req_valid;
   logic [N-1:0]         req_head;
   logic [N-1:0]         req_tail;
   logic [N-1:0][DW-1:0] req_data;
   logic [N-1:0]         req_ready;
   logic [N-1:0]         grant;
   logic                 out_valid;
   logic [DW-1:0]        out_data;
   logic                 out_ready;
   logic                 locked;
   logic [CW-1:0]        pkt_count;

   int total;
   int bad;

   noc_output_arbiter #(.N(N), .DataWidth(DW), .CntWidth(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_head  (req_head),
      .req_tail  (req_tail),
      .req_data  (req_data),
      .req_ready (req_ready),
      .grant     (grant),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .locked    (locked),
      .pkt_count (pkt_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one cycle; registered outputs are stable 1 time unit after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int i, input logic h, input logic t, input logic [31:0] d);
      req_valid[i] = 1'b1;
      req_head[i]  = h;
      req_tail[i]  = t;
      req_data[i]  = d;
   endtask

   task automatic drop(input int i);
      req_valid[i] = 1'b0;
      req_head[i]  = 1'b0;
      req_tail[i]  = 1'b0;
      req_data[i]  = '0;
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) drop(i);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      out_ready = 1'b1;
      clear_all();
      #1;
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_locked", 32'(locked), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_pkt_count", 32'(pkt_count), 32'h0);
      do_reset();

      // 1: single flit on in2
      cyc();
      put(2, 1'b1, 1'b1, 32'hA5A5_0002);
      #1;
      chk("t1_ready_before_grant", 32'(req_ready), 32'h0);
      cyc();
      chk("t1_grant", 32'(grant), 32'b00100);
      chk("t1_locked", 32'(locked), 32'h1);
      chk("t1_ready", 32'(req_ready), 32'b00100);
      chk("t1_out_valid_early", 32'(out_valid), 32'h0);
      cyc();
      chk("t1_out_valid", 32'(out_valid), 32'h1);
      chk("t1_out_data", out_data, 32'hA5A5_0002);
      chk("t1_grant_clr", 32'(grant), 32'h0);
      chk("t1_locked_clr", 32'(locked), 32'h0);
      chk("t1_pkt_count", 32'(pkt_count), 32'h1);
      drop(2);
      cyc();
      chk("t1_out_drained", 32'(out_valid), 32'h0);

      // 2: round-robin from ptr=0 with all inputs offering single-flit packets
      do_reset();
      for (int i = 0; i < N; i++) put(i, 1'b1, 1'b1, 32'h100 + 32'(i));
      for (int k = 0; k < 6; k++) begin
         cyc();
         chk($sformatf("t2_grant_%0d", k), 32'(grant), 32'(1) << (k % N));
         chk($sformatf("t2_gap_%0d", k), 32'(out_valid), 32'(k == 0 ? 0 : 0));
         cyc();
         chk($sformatf("t2_valid_%0d", k), 32'(out_valid), 32'h1);
         chk($sformatf("t2_data_%0d", k), out_data, 32'h100 + 32'(k % N));
      end
      clear_all();
      chk("t2_pkt_count", 32'(pkt_count), 32'd6);

      // 3: wormhole lock, in1 four flits vs in3 head (ptr=1)
      put(1, 1'b1, 1'b0, 32'h11);
      put(3, 1'b1, 1'b1, 32'h33);
      cyc();
      chk("t3_grant_in1", 32'(grant), 32'b00010);
      chk("t3_in3_blocked_0", 32'(req_ready[3]), 32'h0);
      for (int f = 0; f < 3; f++) begin
         cyc();
         chk($sformatf("t3_flit_%0d", f), out_data, 32'h11 + 32'(f));
         chk($sformatf("t3_flit_valid_%0d", f), 32'(out_valid), 32'h1);
         chk($sformatf("t3_grant_hold_%0d", f), 32'(grant), 32'b00010);
         put(1, 1'b0, (f == 2), 32'h12 + 32'(f));
         #1;
         chk($sformatf("t3_in3_blocked_%0d", f + 1), 32'(req_ready[3]), 32'h0);
      end
      cyc();
      chk("t3_tail", out_data, 32'h14);
      chk("t3_tail_valid", 32'(out_valid), 32'h1);
      chk("t3_unlock", 32'(locked), 32'h0);
      drop(1);
      cyc();
      chk("t3_grant_in3", 32'(grant), 32'b01000);
      cyc();
      chk("t3_in3_data", out_data, 32'h33);
      drop(3);
      chk("t3_pkt_count", 32'(pkt_count), 32'd8);

      // 4: backpressure on a 3-flit in4 packet (ptr=4)
      put(4, 1'b1, 1'b0, 32'h41);
      cyc();
      chk("t4_grant", 32'(grant), 32'b10000);
      cyc();
      chk("t4_head", out_data, 32'h41);
      put(4, 1'b0, 1'b0, 32'h42);
      out_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         #1;
         chk($sformatf("t4_ready_stall_%0d", s), 32'(req_ready), 32'h0);
         cyc();
         chk($sformatf("t4_hold_data_%0d", s), out_data, 32'h41);
         chk($sformatf("t4_hold_valid_%0d", s), 32'(out_valid), 32'h1);
      end
      out_ready = 1'b1;
      #1;
      chk("t4_ready_resume", 32'(req_ready), 32'b10000);
      cyc();
      chk("t4_body", out_data, 32'h42);
      put(4, 1'b0, 1'b1, 32'h43);
      cyc();
      chk("t4_tail", out_data, 32'h43);
      chk("t4_tail_valid", 32'(out_valid), 32'h1);
      chk("t4_pkt_count", 32'(pkt_count), 32'd9);
      drop(4);
      cyc();
      chk("t4_drained", 32'(out_valid), 32'h0);

      // 5: reset after the body flit of an in2 packet
      put(2, 1'b1, 1'b0, 32'h21);
      cyc();
      chk("t5_grant", 32'(grant), 32'b00100);
      cyc();
      put(2, 1'b0, 1'b0, 32'h22);
      cyc();
      chk("t5_body", out_data, 32'h22);
      rst_n = 1'b0;
      clear_all();
      #1;
      chk("t5_rst_grant", 32'(grant), 32'h0);
      chk("t5_rst_locked", 32'(locked), 32'h0);
      chk("t5_rst_valid", 32'(out_valid), 32'h0);
      chk("t5_rst_data", out_data, 32'h0);
      chk("t5_rst_count", 32'(pkt_count), 32'h0);
      cyc();
      rst_n = 1'b1;
      put(0, 1'b1, 1'b1, 32'h400);
      put(4, 1'b1, 1'b1, 32'h44);
      cyc();
      chk("t5_ptr0_grant", 32'(grant), 32'b00001);
      cyc();
      chk("t5_in0_data", out_data, 32'h400);
      drop(0);
      cyc();
      chk("t5_in4_grant", 32'(grant), 32'b10000);
      cyc();
      chk("t5_in4_data", out_data, 32'h44);
      chk("t5_pkt_count", 32'(pkt_count), 32'd2);
      drop(4);

      // 6: stray body flit in IDLE
      put(0, 1'b0, 1'b0, 32'hDEAD);
      for (int s = 0; s < 3; s++) begin
         cyc();
         chk($sformatf("t6_grant_%0d", s), 32'(grant), 32'h0);
         chk($sformatf("t6_ready_%0d", s), 32'(req_ready[0]), 32'h0);
         chk($sformatf("t6_locked_%0d", s), 32'(locked), 32'h0);
         chk($sformatf("t6_count_%0d", s), 32'(pkt_count), 32'd2);
      end
      clear_all();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
